// File: rtl/pdp_mem_arbiter_if.sv
// pdp_mem_arbiter_if
// Bundles the three PDP-8 memory requester channels and the single-port
// memory bus that pdp_mem_arbiter multiplexes them onto.
//
// Signal groups:
//   ifu_rd_*  : instruction-fetch read channel (req/addr in, gnt/valid/data out)
//   exec_rd_* : execute-unit read channel      (req/addr in, gnt/valid/data out)
//   exec_wr_* : execute-unit write channel     (req/addr/data in, gnt out)
//   mem_*     : single-port memory bus         (req/we/addr/wdata out, rdata in)
//
// Modports:
//   slave  : the arbiter's view (requests and mem_rdata in; grants, valids,
//            read data and memory strobes out)
//   master : the requesters' and memory's view (the mirror image)
interface pdp_mem_arbiter_if #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 12
);
   logic                  ifu_rd_req;
   logic [ADDR_WIDTH-1:0] ifu_rd_addr;
   logic                  ifu_rd_gnt;
   logic                  ifu_rd_valid;
   logic [DATA_WIDTH-1:0] ifu_rd_data;

   logic                  exec_rd_req;
   logic [ADDR_WIDTH-1:0] exec_rd_addr;
   logic                  exec_rd_gnt;
   logic                  exec_rd_valid;
   logic [DATA_WIDTH-1:0] exec_rd_data;

   logic                  exec_wr_req;
   logic [ADDR_WIDTH-1:0] exec_wr_addr;
   logic [DATA_WIDTH-1:0] exec_wr_data;
   logic                  exec_wr_gnt;

   logic                  mem_req;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [DATA_WIDTH-1:0] mem_rdata;

   modport slave (
      input  ifu_rd_req, ifu_rd_addr,
      output ifu_rd_gnt, ifu_rd_valid, ifu_rd_data,
      input  exec_rd_req, exec_rd_addr,
      output exec_rd_gnt, exec_rd_valid, exec_rd_data,
      input  exec_wr_req, exec_wr_addr, exec_wr_data,
      output exec_wr_gnt,
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output ifu_rd_req, ifu_rd_addr,
      input  ifu_rd_gnt, ifu_rd_valid, ifu_rd_data,
      output exec_rd_req, exec_rd_addr,
      input  exec_rd_gnt, exec_rd_valid, exec_rd_data,
      output exec_wr_req, exec_wr_addr, exec_wr_data,
      input  exec_wr_gnt,
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/pdp_mem_arbiter.sv
// pdp_mem_arbiter
// Shares one single-port, fixed-read-latency memory between the PDP-8
// instruction fetch unit (read) and the execute unit (read and write).
// Only one memory operation is in flight at a time. Priority is
// exec_wr > exec_rd > ifu_rd, except that a fetch which has lost
// STARVE_LIMIT arbitration rounds is promoted to the top.
//
// Ports:
//   clk   : clock, all logic on the rising edge
//   reset : synchronous active-high reset; abandons any in-flight read
//   bus   : pdp_mem_arbiter_if.slave carrying the three requester
//           channels and the memory bus (see the interface file)
//
// Timing for a request sampled in IDLE at cycle N:
//   gnt and mem_req in N+1, mem_rdata captured at the end of N+1+RD_LATENCY,
//   rd_valid in N+2+RD_LATENCY, next IDLE at N+3+RD_LATENCY (read) or
//   N+2 (write). All outputs are registered.
module pdp_mem_arbiter #(
   parameter int ADDR_WIDTH   = 12,
   parameter int DATA_WIDTH   = 12,
   parameter int RD_LATENCY   = 1,
   parameter int STARVE_LIMIT = 4
) (
   input logic              clk,
   input logic              reset,
   pdp_mem_arbiter_if.slave bus
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
   typedef enum logic [1:0] {SRC_IFU, SRC_ERD, SRC_EWR} src_t;

   localparam logic [2:0] WAIT_INIT  = 3'(RD_LATENCY - 1);
   localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);
   localparam logic [3:0] STARVE_MAX = 4'd15;

   state_t                state, state_next;
   src_t                  win, win_next;
   src_t                  pick;
   logic [3:0]            starve_cnt, starve_cnt_next;
   logic [2:0]            wait_cnt, wait_cnt_next;
   logic                  any_req;
   logic                  ifu_promote;

   logic                  ifu_gnt_next, erd_gnt_next, ewr_gnt_next;
   logic                  mem_req_next, mem_we_next;
   logic [ADDR_WIDTH-1:0] mem_addr_next;
   logic [DATA_WIDTH-1:0] mem_wdata_next;
   logic                  ifu_valid_next, erd_valid_next;
   logic [DATA_WIDTH-1:0] ifu_data_next, erd_data_next;

   // Next-state and next-output logic. Every output is registered, so the
   // values computed here appear one cycle later: the grant and memory
   // strobe computed while in IDLE are visible during ISSUE, and the valid
   // computed in the last WAIT cycle is visible during DONE.
   always_comb begin
      state_next      = state;
      win_next        = win;
      starve_cnt_next = starve_cnt;
      wait_cnt_next   = wait_cnt;
      ifu_gnt_next    = 1'b0;
      erd_gnt_next    = 1'b0;
      ewr_gnt_next    = 1'b0;
      mem_req_next    = 1'b0;
      mem_we_next     = 1'b0;
      mem_addr_next   = '0;
      mem_wdata_next  = '0;
      ifu_valid_next  = 1'b0;
      erd_valid_next  = 1'b0;
      ifu_data_next   = bus.ifu_rd_data;
      erd_data_next   = bus.exec_rd_data;

      any_req     = bus.ifu_rd_req | bus.exec_rd_req | bus.exec_wr_req;
      // A fetch that has lost enough rounds overrides the fixed order.
      ifu_promote = bus.ifu_rd_req && (starve_cnt >= STARVE_LIM);

      if (ifu_promote) begin
         pick = SRC_IFU;
      end else if (bus.exec_wr_req) begin
         pick = SRC_EWR;
      end else if (bus.exec_rd_req) begin
         pick = SRC_ERD;
      end else begin
         pick = SRC_IFU;
      end

      case (state)
         IDLE: begin
            if (any_req) begin
               state_next   = ISSUE;
               win_next     = pick;
               mem_req_next = 1'b1;
               case (pick)
                  SRC_EWR: begin
                     ewr_gnt_next   = 1'b1;
                     mem_we_next    = 1'b1;
                     mem_addr_next  = bus.exec_wr_addr;
                     mem_wdata_next = bus.exec_wr_data;
                  end
                  SRC_ERD: begin
                     erd_gnt_next  = 1'b1;
                     mem_addr_next = bus.exec_rd_addr;
                  end
                  default: begin
                     ifu_gnt_next  = 1'b1;
                     mem_addr_next = bus.ifu_rd_addr;
                  end
               endcase
               // Starvation only counts rounds where the fetch was actually
               // asking and someone else won.
               if (pick == SRC_IFU) begin
                  starve_cnt_next = '0;
               end else if (bus.ifu_rd_req && (starve_cnt != STARVE_MAX)) begin
                  starve_cnt_next = starve_cnt + 4'd1;
               end
            end
         end

         ISSUE: begin
            if (win == SRC_EWR) begin
               state_next = IDLE;
            end else begin
               state_next    = WAIT;
               wait_cnt_next = WAIT_INIT;
            end
         end

         WAIT: begin
            // The last WAIT cycle is the one in which mem_rdata is valid.
            if (wait_cnt == 3'd0) begin
               state_next = DONE;
               if (win == SRC_IFU) begin
                  ifu_valid_next = 1'b1;
                  ifu_data_next  = bus.mem_rdata;
               end else begin
                  erd_valid_next = 1'b1;
                  erd_data_next  = bus.mem_rdata;
               end
            end else begin
               wait_cnt_next = wait_cnt - 3'd1;
            end
         end

         DONE: begin
            state_next = IDLE;
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State, counters and all output registers. Reset returns to IDLE and
   // zeroes every output, which also discards any read still in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state             <= IDLE;
         win               <= SRC_IFU;
         starve_cnt        <= '0;
         wait_cnt          <= '0;
         bus.ifu_rd_gnt    <= 1'b0;
         bus.exec_rd_gnt   <= 1'b0;
         bus.exec_wr_gnt   <= 1'b0;
         bus.mem_req       <= 1'b0;
         bus.mem_we        <= 1'b0;
         bus.mem_addr      <= '0;
         bus.mem_wdata     <= '0;
         bus.ifu_rd_valid  <= 1'b0;
         bus.exec_rd_valid <= 1'b0;
         bus.ifu_rd_data   <= '0;
         bus.exec_rd_data  <= '0;
      end else begin
         state             <= state_next;
         win               <= win_next;
         starve_cnt        <= starve_cnt_next;
         wait_cnt          <= wait_cnt_next;
         bus.ifu_rd_gnt    <= ifu_gnt_next;
         bus.exec_rd_gnt   <= erd_gnt_next;
         bus.exec_wr_gnt   <= ewr_gnt_next;
         bus.mem_req       <= mem_req_next;
         bus.mem_we        <= mem_we_next;
         bus.mem_addr      <= mem_addr_next;
         bus.mem_wdata     <= mem_wdata_next;
         bus.ifu_rd_valid  <= ifu_valid_next;
         bus.exec_rd_valid <= erd_valid_next;
         bus.ifu_rd_data   <= ifu_data_next;
         bus.exec_rd_data  <= erd_data_next;
      end
   end

endmodule

// File: tb/tb_pdp_mem_arbiter.sv
// tb_pdp_mem_arbiter
// Self-checking bench for pdp_mem_arbiter. Plays the three requesters and a
// single-port memory with RD_LAT cycles of read latency. A directed vector
// table covers the basic fetch and write-then-read flows, hand-written
// sequences cover starvation, reset during WAIT and back-to-back reads, and
// a randomized phase is scored against a transaction-level model that
// predicts grant, memory and valid cycles from the arbitration rules.
`timescale 1ns/1ps
module tb_pdp_mem_arbiter;

   localparam int AW          = 12;
   localparam int DW          = 12;
   localparam int RD_LAT      = 2;
   localparam int STARVE      = 4;
   localparam int RAND_CYCLES = 3000;
   localparam int EXP_DEPTH   = RAND_CYCLES + 16;

   logic clk = 1'b0;
   logic reset;
   logic mem_init;
   int   checks = 0;
   int   errors = 0;
   logic mon_en = 1'b0;

   always #5 clk = ~clk;

   pdp_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   pdp_mem_arbiter #(
      .ADDR_WIDTH  (AW),
      .DATA_WIDTH  (DW),
      .RD_LATENCY  (RD_LAT),
      .STARVE_LIMIT(STARVE)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   // Initial memory contents, shared by the memory device and the model.
   function automatic logic [DW-1:0] init_word(input int a);
      if (a == 'o200) return DW'('o7300);
      return DW'((a * 37 + 5) & 'hFFF);
   endfunction

   // Memory device: writes land at the end of the strobe cycle; read data
   // travels down an RD_LAT deep pipe and is garbage whenever no read is due.
   logic [DW-1:0] phys_mem [4096];
   logic [DW-1:0] rd_pipe  [RD_LAT];

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 4096; i++) phys_mem[i] <= init_word(i);
      end else if (bus.mem_req && bus.mem_we) begin
         phys_mem[bus.mem_addr] <= bus.mem_wdata;
      end
      rd_pipe[0] <= (bus.mem_req && !bus.mem_we) ? phys_mem[bus.mem_addr] : DW'($urandom);
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
   end

   assign bus.mem_rdata = rd_pipe[RD_LAT-1];

   typedef struct {
      logic          ifu_req;
      logic [AW-1:0] ifu_addr;
      logic          erd_req;
      logic [AW-1:0] erd_addr;
      logic          ewr_req;
      logic [AW-1:0] ewr_addr;
      logic [DW-1:0] ewr_data;
      logic [2:0]    exp_gnt;
      logic          exp_mreq;
      logic          exp_we;
      logic [AW-1:0] exp_addr;
      logic [DW-1:0] exp_wdata;
      logic [1:0]    exp_valid;
      logic [DW-1:0] exp_data;
   } vec_t;

   function automatic vec_t mk(input logic ir, input int ia, input logic er, input int ea,
                               input logic wr, input int wa, input int wd,
                               input logic [2:0] g, input logic mr, input logic we,
                               input int ma, input int mw, input logic [1:0] v, input int d);
      vec_t r;
      r.ifu_req  = ir;      r.ifu_addr  = AW'(ia);
      r.erd_req  = er;      r.erd_addr  = AW'(ea);
      r.ewr_req  = wr;      r.ewr_addr  = AW'(wa);   r.ewr_data = DW'(wd);
      r.exp_gnt  = g;       r.exp_mreq  = mr;        r.exp_we   = we;
      r.exp_addr = AW'(ma); r.exp_wdata = DW'(mw);
      r.exp_valid = v;      r.exp_data  = DW'(d);
      return r;
   endfunction

   function automatic logic [2:0] gnt_vec();
      return {bus.exec_wr_gnt, bus.exec_rd_gnt, bus.ifu_rd_gnt};
   endfunction

   function automatic logic [1:0] valid_vec();
      return {bus.exec_rd_valid, bus.ifu_rd_valid};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      bus.ifu_rd_req   = v.ifu_req;
      bus.ifu_rd_addr  = v.ifu_addr;
      bus.exec_rd_req  = v.erd_req;
      bus.exec_rd_addr = v.erd_addr;
      bus.exec_wr_req  = v.ewr_req;
      bus.exec_wr_addr = v.ewr_addr;
      bus.exec_wr_data = v.ewr_data;
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_gnt"},   32'(gnt_vec()),            32'd0);
      checkOutput({tag, "_valid"}, 32'(valid_vec()),          32'd0);
      checkOutput({tag, "_mreq"},  32'(bus.mem_req),          32'd0);
      checkOutput({tag, "_mwe"},   32'(bus.mem_we),           32'd0);
      checkOutput({tag, "_maddr"}, 32'(bus.mem_addr),         32'd0);
      checkOutput({tag, "_mwdat"}, 32'(bus.mem_wdata),        32'd0);
      checkOutput({tag, "_idata"}, 32'(bus.ifu_rd_data),      32'd0);
      checkOutput({tag, "_edata"}, 32'(bus.exec_rd_data),     32'd0);
   endtask

   // Leaves the bench at a falling edge with the arbiter idle in cycle 0.
   task automatic applyReset();
      applyStimulus(mk(0,0,0,0,0,0,0, 0,0,0,0,0,0,0));
      reset    = 1'b1;
      mem_init = 1'b1;
      repeat (2) @(negedge clk);
      reset    = 1'b0;
      mem_init = 1'b0;
      @(negedge clk);
   endtask

   // Structural invariants checked every cycle: one grant at most, one valid
   // at most, and the memory strobe coincides exactly with a grant.
   always @(negedge clk) begin
      if (mon_en) begin
         checkOutput("mon_onehot_gnt",   32'($countones(gnt_vec()) <= 1),   32'd1);
         checkOutput("mon_onehot_valid", 32'($countones(valid_vec()) <= 1), 32'd1);
         checkOutput("mon_mreq_is_gnt",  32'(bus.mem_req),                  32'(|gnt_vec()));
      end
   end

   // Random-phase model state.
   logic [2:0]    exp_g  [EXP_DEPTH];
   logic          exp_m  [EXP_DEPTH];
   logic          exp_we [EXP_DEPTH];
   logic [AW-1:0] exp_a  [EXP_DEPTH];
   logic [DW-1:0] exp_wd [EXP_DEPTH];
   logic [1:0]    exp_v  [EXP_DEPTH];
   logic [DW-1:0] exp_d  [EXP_DEPTH];
   logic [DW-1:0] ref_mem [4096];

   vec_t vecs [18];
   vec_t cur;
   int   order [$];
   int   gcyc  [$];

   initial begin
      // Directed vectors: each row is checked at a falling edge, then its
      // inputs are driven for that same cycle.
      //              ifu        erd          ewr                 gnt   mr we addr   wdata   v     data
      vecs[0]  = mk(1,'o200, 0,0,     0,0,0,          3'b000,0,0,0,     0,      2'b00,0);
      vecs[1]  = mk(1,'o200, 0,0,     0,0,0,          3'b001,1,0,'o200, 0,      2'b00,0);
      vecs[2]  = mk(0,0,     0,0,     0,0,0,          3'b000,0,0,0,     0,      2'b00,0);
      vecs[3]  = mk(0,0,     0,0,     0,0,0,          3'b000,0,0,0,     0,      2'b00,0);
      vecs[4]  = mk(0,0,     0,0,     0,0,0,          3'b000,0,0,0,     0,      2'b01,'o7300);
      vecs[5]  = mk(0,0,     1,'o100, 1,'o100,'o1234, 3'b000,0,0,0,     0,      2'b00,0);
      vecs[6]  = mk(0,0,     1,'o100, 1,'o100,'o1234, 3'b100,1,1,'o100, 'o1234, 2'b00,0);
      vecs[7]  = mk(0,0,     1,'o100, 0,0,0,          3'b000,0,0,0,     0,      2'b00,0);
      vecs[8]  = mk(0,0,     1,'o100, 0,0,0,          3'b010,1,0,'o100, 0,      2'b00,0);
      vecs[9]  = mk(0,0,     0,0,     0,0,0,          3'b000,0,0,0,     0,      2'b00,0);
      vecs[10] = mk(0,0,     0,0,     0,0,0,          3'b000,0,0,0,     0,      2'b00,0);
      vecs[11] = mk(0,0,     0,0,     0,0,0,          3'b000,0,0,0,     0,      2'b10,'o1234);
      vecs[12] = mk(1,'o300, 0,0,     1,5,'o777,      3'b000,0,0,0,     0,      2'b00,0);
      vecs[13] = mk(0,0,     0,0,     1,5,'o777,      3'b100,1,1,5,     'o777,  2'b00,0);
      for (int i = 14; i < 18; i++)
         vecs[i] = mk(0,0,   0,0,     0,0,0,          3'b000,0,0,0,     0,      2'b00,0);

      applyReset();
      mon_en = 1'b1;
      checkAllZero("reset");

      $display("[TB] directed vector table");
      for (int i = 0; i < 18; i++) begin
         checkOutput($sformatf("vec%0d_gnt", i),   32'(gnt_vec()),   32'(vecs[i].exp_gnt));
         checkOutput($sformatf("vec%0d_mreq", i),  32'(bus.mem_req), 32'(vecs[i].exp_mreq));
         if (vecs[i].exp_mreq) begin
            checkOutput($sformatf("vec%0d_we", i),   32'(bus.mem_we),   32'(vecs[i].exp_we));
            checkOutput($sformatf("vec%0d_addr", i), 32'(bus.mem_addr), 32'(vecs[i].exp_addr));
            if (vecs[i].exp_we)
               checkOutput($sformatf("vec%0d_wdata", i), 32'(bus.mem_wdata), 32'(vecs[i].exp_wdata));
         end
         checkOutput($sformatf("vec%0d_valid", i), 32'(valid_vec()), 32'(vecs[i].exp_valid));
         if (vecs[i].exp_valid[0])
            checkOutput($sformatf("vec%0d_idata", i), 32'(bus.ifu_rd_data), 32'(vecs[i].exp_data));
         if (vecs[i].exp_valid[1])
            checkOutput($sformatf("vec%0d_edata", i), 32'(bus.exec_rd_data), 32'(vecs[i].exp_data));
         applyStimulus(vecs[i]);
         @(negedge clk);
      end

      // Starvation: fetch and exec read both keep asking; each drops for the
      // single cycle after its grant. Fetch must lose exactly STARVE rounds,
      // win, and then lose exactly STARVE rounds again from a cleared count.
      $display("[TB] starvation escalation");
      applyReset();
      order.delete();
      begin
         logic ig_prev = 1'b0;
         logic eg_prev = 1'b0;
         for (int c = 0; c < 400 && order.size() < 2 * (STARVE + 1); c++) begin
            if (bus.ifu_rd_gnt)  order.push_back(0);
            if (bus.exec_rd_gnt) order.push_back(1);
            if (bus.exec_wr_gnt) order.push_back(2);
            cur = mk(!ig_prev, 'o20 + c % 8, !eg_prev, 'o40 + c % 8, 0,0,0, 0,0,0,0,0,0,0);
            ig_prev = bus.ifu_rd_gnt;
            eg_prev = bus.exec_rd_gnt;
            applyStimulus(cur);
            @(negedge clk);
         end
      end
      checkOutput("starve_rounds_seen", 32'(order.size()), 32'(2 * (STARVE + 1)));
      for (int i = 0; i < order.size(); i++)
         checkOutput($sformatf("starve_round%0d_winner", i), 32'(order[i]),
                     ((i % (STARVE + 1)) == STARVE) ? 32'd0 : 32'd1);
      applyStimulus(mk(0,0,0,0,0,0,0, 0,0,0,0,0,0,0));
      repeat (RD_LAT + 4) @(negedge clk);

      // Reset while waiting on read data: the read is dropped silently.
      $display("[TB] reset during WAIT");
      applyReset();
      applyStimulus(mk(0,0, 1,'o200, 0,0,0, 0,0,0,0,0,0,0));
      @(negedge clk);
      checkOutput("rstwait_gnt", 32'(gnt_vec()), 32'b010);
      @(negedge clk);
      applyStimulus(mk(0,0,0,0,0,0,0, 0,0,0,0,0,0,0));
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checkAllZero("rstwait_after");
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         checkOutput("rstwait_no_valid", 32'(valid_vec()), 32'd0);
      end
      applyStimulus(mk(0,0, 1,'o201, 0,0,0, 0,0,0,0,0,0,0));
      @(negedge clk);
      checkOutput("rstwait_regrant",      32'(gnt_vec()),  32'b010);
      checkOutput("rstwait_regrant_addr", 32'(bus.mem_addr), 32'('o201));
      applyStimulus(mk(0,0,0,0,0,0,0, 0,0,0,0,0,0,0));
      repeat (RD_LAT + 1) @(negedge clk);
      checkOutput("rstwait_revalid", 32'(valid_vec()), 32'b10);
      checkOutput("rstwait_redata",  32'(bus.exec_rd_data), 32'(init_word('o201)));
      @(negedge clk);

      // Back-to-back exec reads: grants must be RD_LAT+3 cycles apart.
      $display("[TB] back-to-back reads");
      applyReset();
      gcyc.delete();
      begin
         logic eg_prev = 1'b0;
         for (int c = 0; c < 200 && gcyc.size() < 6; c++) begin
            if (bus.exec_rd_gnt) gcyc.push_back(c);
            cur = mk(0,0, !eg_prev, c % 64, 0,0,0, 0,0,0,0,0,0,0);
            eg_prev = bus.exec_rd_gnt;
            applyStimulus(cur);
            @(negedge clk);
         end
      end
      checkOutput("b2b_grants_seen", 32'(gcyc.size()), 32'd6);
      for (int i = 1; i < gcyc.size(); i++)
         checkOutput($sformatf("b2b_spacing%0d", i), 32'(gcyc[i] - gcyc[i-1]), 32'(RD_LAT + 3));
      applyStimulus(mk(0,0,0,0,0,0,0, 0,0,0,0,0,0,0));
      repeat (RD_LAT + 4) @(negedge clk);

      // Randomized traffic against the transaction-level model.
      $display("[TB] randomized traffic, %0d cycles", RAND_CYCLES);
      applyReset();
      for (int i = 0; i < 4096; i++) ref_mem[i] = init_word(i);
      for (int i = 0; i < EXP_DEPTH; i++) begin
         exp_g[i] = '0; exp_m[i] = 1'b0; exp_we[i] = 1'b0; exp_a[i] = '0;
         exp_wd[i] = '0; exp_v[i] = '0; exp_d[i] = '0;
      end
      begin
         logic          pend [3];
         logic          won  [3];
         logic [AW-1:0] addr [3];
         logic [DW-1:0] wdat;
         int            starve;
         int            next_sample;
         int            w;
         logic [2:0]    reqs;
         for (int r = 0; r < 3; r++) begin
            pend[r] = 1'b0; won[r] = 1'b0; addr[r] = '0;
         end
         wdat = '0;
         starve = 0;
         next_sample = 0;
         for (int c = 0; c < RAND_CYCLES; c++) begin
            checkOutput("rnd_gnt",   32'(gnt_vec()),   32'(exp_g[c]));
            checkOutput("rnd_mreq",  32'(bus.mem_req), 32'(exp_m[c]));
            if (exp_m[c]) begin
               checkOutput("rnd_we",   32'(bus.mem_we),   32'(exp_we[c]));
               checkOutput("rnd_addr", 32'(bus.mem_addr), 32'(exp_a[c]));
               if (exp_we[c]) checkOutput("rnd_wdata", 32'(bus.mem_wdata), 32'(exp_wd[c]));
            end
            checkOutput("rnd_valid", 32'(valid_vec()), 32'(exp_v[c]));
            if (exp_v[c][0]) checkOutput("rnd_idata", 32'(bus.ifu_rd_data),  32'(exp_d[c]));
            if (exp_v[c][1]) checkOutput("rnd_edata", 32'(bus.exec_rd_data), 32'(exp_d[c]));

            // Requesters: drop the cycle after a grant, occasionally withdraw
            // an ungranted request, otherwise raise new ones at random.
            for (int r = 0; r < 3; r++) begin
               if (c > 0 && exp_g[c-1][r]) begin
                  pend[r] = 1'b0;
                  won[r]  = 1'b0;
               end else if (!pend[r]) begin
                  if ($urandom_range(0, 3) == 0) begin
                     pend[r] = 1'b1;
                     addr[r] = AW'($urandom_range(0, 31));
                     if (r == 2) wdat = DW'($urandom);
                  end
               end else if (!won[r] && $urandom_range(0, 15) == 0) begin
                  pend[r] = 1'b0;
               end
            end
            applyStimulus(mk(pend[0], int'(addr[0]), pend[1], int'(addr[1]),
                             pend[2], int'(addr[2]), int'(wdat), 0,0,0,0,0,0,0));

            if (c == next_sample) begin
               reqs = {pend[2], pend[1], pend[0]};
               if (reqs == 3'b000) begin
                  next_sample = c + 1;
               end else begin
                  if (pend[0] && starve >= STARVE) w = 0;
                  else if (pend[2])                w = 2;
                  else if (pend[1])                w = 1;
                  else                             w = 0;
                  if (w == 0)       starve = 0;
                  else if (pend[0]) starve = (starve < 15) ? starve + 1 : 15;
                  won[w] = 1'b1;
                  exp_g[c+1][w] = 1'b1;
                  exp_m[c+1]    = 1'b1;
                  exp_a[c+1]    = addr[w];
                  if (w == 2) begin
                     exp_we[c+1]   = 1'b1;
                     exp_wd[c+1]   = wdat;
                     ref_mem[addr[w]] = wdat;
                     next_sample   = c + 2;
                  end else begin
                     exp_v[c+2+RD_LAT][w] = 1'b1;
                     exp_d[c+2+RD_LAT]    = ref_mem[addr[w]];
                     next_sample          = c + 3 + RD_LAT;
                  end
               end
            end
            @(negedge clk);
         end
      end
      applyStimulus(mk(0,0,0,0,0,0,0, 0,0,0,0,0,0,0));
      repeat (RD_LAT + 4) @(negedge clk);

      mon_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
